// File: rtl/piso_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_pkg : shared types and helpers for the PISO serializer           |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package piso_pkg;

    localparam int c_DEFAULT_WIDTH = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Counter width able to hold 0..width (parity cycle needs the extra code)
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_shift_core : shift register, bit counter and load/shift datapath |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module piso_shift_core #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
            assign o_bit     = r_shreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
            assign o_bit     = r_shreg[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
            r_count <= '0;
        end else if (i_shift) begin
            r_shreg <= w_shifted;
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_serializer : valid/ready parallel-in, serial-out transmitter     |
// | Optional macro PARITY_BIT_EN appends an even-parity bit to each word  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = c_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             done
);

    localparam int c_CNT_W = cnt_w(WIDTH);
`ifdef PARITY_BIT_EN
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH);
`else
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
`endif

    piso_state_t        r_state;
    piso_state_t        w_state_nxt;
    logic [c_CNT_W-1:0] w_count;
    logic               w_core_bit;
    logic               w_tx_bit;
    logic               w_busy;
    logic               w_at_last;
    logic               w_accept;
    logic               w_shift;

    piso_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (c_CNT_W)
    ) u_core (
        .clk     (clock),
        .rst     (reset),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (data_in),
        .o_bit   (w_core_bit),
        .o_count (w_count)
    );

`ifdef PARITY_BIT_EN
    logic r_parity;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^data_in;
        end
    end

    // The parity bit occupies the final count slot after all data bits
    assign w_tx_bit = w_at_last ? r_parity : w_core_bit;
`else
    assign w_tx_bit = w_core_bit;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state == SHIFT);
        w_at_last   = (w_count == c_LAST);
        load_ready  = !w_busy || w_at_last;
        w_accept    = load_valid && load_ready;
        w_shift     = w_busy && !w_at_last;
        frame       = w_busy;
        done        = w_busy && w_at_last;
        serial_out  = w_busy ? w_tx_bit : 1'b0;

        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (w_at_last && !w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire
